// File: rtl/sync_source_scheduler_pkg.sv
// Shared types and constants for the sync source scheduler.
// SYNC_TIME_W is also used by the DDS correction block.
package sync_source_scheduler_pkg;

  localparam int SYNC_TIME_W = 64;
  localparam int DEF_TIMEOUT = 125000000;
  localparam int DEF_MIN_GAP = 1024;

  typedef enum logic [1:0] {
    SEARCH   = 2'd0,
    LOCKED   = 2'd1,
    HOLDOVER = 2'd2
  } sched_state_e;

endpackage

// File: rtl/sync_source_scheduler_src_select.sv
// Source picker: preferred source if it is eligible,
// otherwise the lowest eligible index.
module sync_src_select #(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 2
) (
  input  logic [NUM_SRC-1:0] eligible,
  input  logic [SRC_W-1:0]   pref_src,
  output logic [SRC_W-1:0]   sel,
  output logic               any_eligible
);

  always_comb begin
    sel          = '0;
    any_eligible = |eligible;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        sel = SRC_W'(i);
      end
    end
    if (int'(pref_src) < NUM_SRC) begin
      if (eligible[pref_src]) begin
        sel = pref_src;
      end
    end
  end

endmodule

// File: rtl/sync_source_scheduler.sv
// Locks onto one timestamp source, filters glitches, and fails
// over through holdover when the locked source goes quiet.
module sync_source_scheduler
  import sync_source_scheduler_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 2,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int MIN_GAP = DEF_MIN_GAP
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_SRC*SYNC_TIME_W-1:0] src_time,
  input  logic [NUM_SRC-1:0]             src_valid,
  input  logic [NUM_SRC-1:0]             src_enable,
  input  logic [SRC_W-1:0]               pref_src,
  output logic [SYNC_TIME_W-1:0]         Time_sync,
  output logic                           sync_valid,
  output logic                           corr_restart,
  output logic [SRC_W-1:0]               active_src,
  output logic                           locked,
  output logic                           holdover,
  output logic [15:0]                    switch_cnt
);

  sched_state_e state_q, state_d;

  logic [31:0]            gap_q;
  logic [SRC_W-1:0]       active_q;
  logic [SRC_W-1:0]       sel;
  logic [NUM_SRC-1:0]     elig;
  logic                   any_elig;
  logic                   acquire;
  logic                   accept;
  logic                   pend_q;
  logic                   valid_q;
  logic                   restart_q;
  logic [15:0]            switch_q;
  logic [SYNC_TIME_W-1:0] cap_q;
  logic [SYNC_TIME_W-1:0] time_q;
  logic [SYNC_TIME_W-1:0] times [NUM_SRC];

  assign elig = src_valid & src_enable;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      times[i] = src_time[i*SYNC_TIME_W +: SYNC_TIME_W];
    end
  end

  sync_src_select #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_select (
    .eligible     (elig),
    .pref_src     (pref_src),
    .sel          (sel),
    .any_eligible (any_elig)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Disable outranks a same-cycle sample; an accept outranks timeout.
  always_comb begin
    state_d = state_q;
    acquire = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      SEARCH, HOLDOVER: begin
        if (any_elig) begin
          acquire = 1'b1;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (!src_enable[active_q]) begin
          state_d = HOLDOVER;
        end else if (elig[active_q] &&
                     gap_q >= 32'(MIN_GAP)) begin
          accept = 1'b1;
        end else if (gap_q == 32'(TIMEOUT)) begin
          state_d = HOLDOVER;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gap_q     <= '0;
      active_q  <= '0;
      pend_q    <= 1'b0;
      valid_q   <= 1'b0;
      restart_q <= 1'b0;
      switch_q  <= '0;
      cap_q     <= '0;
      time_q    <= '0;
    end else begin
      restart_q <= acquire;
      pend_q    <= acquire;
      valid_q   <= accept | pend_q;
      if (acquire || accept) begin
        gap_q <= '0;
      end else if (gap_q != 32'(TIMEOUT)) begin
        gap_q <= gap_q + 32'd1;
      end
      if (acquire) begin
        active_q <= sel;
        cap_q    <= times[sel];
      end
      if (acquire && state_q == HOLDOVER &&
          sel != active_q && switch_q != 16'hFFFF) begin
        switch_q <= switch_q + 16'd1;
      end
      // Acquired sample lags its restart pulse by one cycle.
      if (pend_q) begin
        time_q <= cap_q;
      end else if (accept) begin
        time_q <= times[active_q];
      end
    end
  end

  assign Time_sync    = time_q;
  assign sync_valid   = valid_q;
  assign corr_restart = restart_q;
  assign active_src   = active_q;
  assign locked       = (state_q == LOCKED);
  assign holdover     = (state_q == HOLDOVER);
  assign switch_cnt   = switch_q;

endmodule

// File: tb/tb_sync_source_scheduler.sv
// Bench for sync_source_scheduler: directed scenarios plus random
// traffic, checked every cycle against a cycle-count reference model.
module tb_sync_source_scheduler;

  localparam int TMO  = 100;
  localparam int MGAP = 10;
  localparam int M_SEARCH = 0;
  localparam int M_LOCK   = 1;
  localparam int M_HOLD   = 2;

  logic         clk;
  logic         reset_n;
  logic [255:0] src_time;
  logic [3:0]   src_valid;
  logic [3:0]   src_enable;
  logic [1:0]   pref_src;
  logic [63:0]  Time_sync;
  logic         sync_valid;
  logic         corr_restart;
  logic [1:0]   active_src;
  logic         locked;
  logic         holdover;
  logic [15:0]  switch_cnt;

  logic [63:0] t_in [4];

  assign src_time = {t_in[3], t_in[2], t_in[1], t_in[0]};

  sync_source_scheduler #(
    .NUM_SRC (4),
    .SRC_W   (2),
    .TIMEOUT (TMO),
    .MIN_GAP (MGAP)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .src_time     (src_time),
    .src_valid    (src_valid),
    .src_enable   (src_enable),
    .pref_src     (pref_src),
    .Time_sync    (Time_sync),
    .sync_valid   (sync_valid),
    .corr_restart (corr_restart),
    .active_src   (active_src),
    .locked       (locked),
    .holdover     (holdover),
    .switch_cnt   (switch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int          m_mode;
  int          m_act;
  int          m_sw;
  int          m_clr;
  bit          m_pend;
  logic [63:0] m_pval;
  logic [63:0] m_time;
  bit          e_valid;
  bit          e_rst;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] e, input int p);
    if (e[p]) return p;
    for (int i = 0; i < 4; i++) if (e[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_mode  = M_SEARCH;
    m_act   = 0;
    m_sw    = 0;
    m_clr   = -1000;
    m_pend  = 0;
    m_pval  = '0;
    m_time  = '0;
    e_valid = 0;
    e_rst   = 0;
  endtask

  // Gap is derived from the cycle of the last clear, capped at TMO.
  task automatic model_step();
    logic [3:0] e;
    int gap;
    int s;
    e = src_valid & src_enable;
    gap = cyc - m_clr - 1;
    if (gap > TMO) gap = TMO;
    e_valid = 0;
    e_rst   = 0;
    if (m_pend) begin
      e_valid = 1;
      m_time  = m_pval;
      m_pend  = 0;
    end
    if (m_mode != M_LOCK) begin
      if (e != 4'b0) begin
        s = pick(e, int'(pref_src));
        if (m_mode == M_HOLD && s != m_act && m_sw < 65535) m_sw++;
        m_act  = s;
        m_pval = t_in[s];
        m_pend = 1;
        e_rst  = 1;
        m_clr  = cyc;
        m_mode = M_LOCK;
      end
    end else if (!src_enable[m_act]) begin
      m_mode = M_HOLD;
    end else if (e[m_act] && gap >= MGAP) begin
      e_valid = 1;
      m_time  = t_in[m_act];
      m_clr   = cyc;
    end else if (gap == TMO) begin
      m_mode = M_HOLD;
    end
  endtask

  task automatic compare_all();
    chk("sync_valid", 64'(sync_valid), 64'(e_valid));
    chk("corr_restart", 64'(corr_restart), 64'(e_rst));
    chk("Time_sync", Time_sync, m_time);
    chk("active_src", 64'(active_src), 64'(m_act));
    chk("locked", 64'(locked), 64'(m_mode == M_LOCK));
    chk("holdover", 64'(holdover), 64'(m_mode == M_HOLD));
    chk("switch_cnt", 64'(switch_cnt), 64'(m_sw));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    compare_all();
  endtask

  task automatic idle(input int n);
    src_valid = 4'b0;
    repeat (n) step();
  endtask

  task automatic pulse(input logic [3:0] v);
    src_valid = v;
    step();
    src_valid = 4'b0;
  endtask

  logic [3:0] rv;
  int         j;

  initial begin
    reset_n    = 1'b0;
    src_valid  = 4'b0;
    src_enable = 4'b0;
    pref_src   = 2'd0;
    for (int i = 0; i < 4; i++) t_in[i] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    reset_n = 1'b1;

    // Acquisition from SEARCH; pref 1 is not pulsing, lowest wins
    src_enable = 4'hF;
    pref_src   = 2'd1;
    t_in[0] = 64'h10; t_in[1] = 64'h20;
    t_in[2] = 64'h30; t_in[3] = 64'h40;
    pulse(4'b0101);
    chk("t1_restart", 64'(corr_restart), 64'd1);
    chk("t1_active", 64'(active_src), 64'd0);
    chk("t1_locked", 64'(locked), 64'd1);
    idle(1);
    chk("t1_valid", 64'(sync_valid), 64'd1);
    chk("t1_time", Time_sync, 64'h10);

    // Glitch filter: gap 5 dropped, gap 12 forwarded
    idle(4);
    t_in[0] = 64'h100;
    pulse(4'b0001);
    chk("t3_drop", 64'(sync_valid), 64'd0);
    idle(6);
    t_in[0] = 64'h200;
    pulse(4'b0001);
    chk("t3_valid", 64'(sync_valid), 64'd1);
    chk("t3_time", Time_sync, 64'h200);

    // Timeout then failover to source 3
    idle(100);
    chk("t4_pre_hold", 64'(holdover), 64'd0);
    idle(1);
    chk("t4_hold", 64'(holdover), 64'd1);
    chk("t4_unlock", 64'(locked), 64'd0);
    t_in[3] = 64'h999;
    pulse(4'b1000);
    chk("t4_restart", 64'(corr_restart), 64'd1);
    chk("t4_active", 64'(active_src), 64'd3);
    chk("t4_switch", 64'(switch_cnt), 64'd1);
    idle(1);
    chk("t4_time", Time_sync, 64'h999);

    // Accept on the very cycle gap reaches TIMEOUT
    idle(99);
    t_in[3] = 64'hABC;
    pulse(4'b1000);
    chk("t5_edge_valid", 64'(sync_valid), 64'd1);
    chk("t5_edge_lock", 64'(locked), 64'd1);
    chk("t5_edge_time", Time_sync, 64'hABC);

    // Disable coincident with a sample
    idle(20);
    src_enable = 4'b0111;
    t_in[3] = 64'hDEAD;
    pulse(4'b1000);
    chk("t5_dis_drop", 64'(sync_valid), 64'd0);
    chk("t5_dis_hold", 64'(holdover), 64'd1);
    src_enable = 4'hF;

    // Preference honoured at selection, never preempts
    pref_src = 2'd2;
    t_in[2] = 64'h30;
    pulse(4'b0101);
    chk("t2_active", 64'(active_src), 64'd2);
    idle(1);
    chk("t2_time", Time_sync, 64'h30);
    pref_src = 2'd0;
    idle(15);
    pulse(4'b0001);
    chk("t2_stay", 64'(active_src), 64'd2);
    chk("t2_novalid", 64'(sync_valid), 64'd0);

    // Random traffic
    for (int k = 0; k < 4000; k++) begin
      rv = 4'b0;
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(15) == 0) rv[i] = 1'b1;
        t_in[i] = {$urandom, $urandom};
      end
      if ($urandom_range(119) == 0) begin
        j = $urandom_range(3);
        src_enable[j] = ~src_enable[j];
      end
      if ($urandom_range(249) == 0) src_enable = 4'hF;
      if ($urandom_range(31) == 0) pref_src = 2'($urandom_range(3));
      if ($urandom_range(299) == 0) idle(100 + $urandom_range(20));
      src_valid = rv;
      step();
    end

    // Reset between restart and emit
    src_enable = 4'hF;
    idle(110);
    t_in[1] = 64'h5555;
    pulse(4'b0010);
    chk("t6_restart", 64'(corr_restart), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("t6_rst_time", Time_sync, 64'd0);
    chk("t6_rst_valid", 64'(sync_valid), 64'd0);
    chk("t6_rst_restart", 64'(corr_restart), 64'd0);
    chk("t6_rst_active", 64'(active_src), 64'd0);
    chk("t6_rst_locked", 64'(locked), 64'd0);
    chk("t6_rst_hold", 64'(holdover), 64'd0);
    chk("t6_rst_switch", 64'(switch_cnt), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle(5);
    chk("t6_no_valid", 64'(sync_valid), 64'd0);
    t_in[3] = 64'h77;
    pulse(4'b1000);
    chk("t6_reacq_sw", 64'(switch_cnt), 64'd0);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
